dm_arbiter: RTL and testbench

//  Shares the single data memory (dm) between two requesters: M0 = CPU load/store path,
//  M1 = debug/DMA loader. Round-robin arbitration, latched request, alignment/range checks,

---
 rtl/dm_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_dm_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin owner of the data memory port,
// shared by the CPU load/store path (M0) and the debug/DMA loader (M1).
module dm_arbiter #(
  parameter int DEPTH = 128,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [2:0]    m0_type,
  output logic          m0_done,
  output logic          m0_err,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [2:0]    m1_type,
  output logic          m1_done,
  output logic          m1_err,
  output logic [31:0]   m1_rdata,
  output logic          dm_DMWr,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic [2:0]    dm_DMType,
  input  logic [31:0]   dm_dout,
  output logic          busy
);

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_last_gnt;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_type;
  logic [31:0]   r_rdata0;
  logic [31:0]   r_rdata1;

  logic          w_any;
  logic          w_win;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_wdata;
  logic [2:0]    w_type;

  logic          w_type_ok;
  logic          w_align_ok;
  logic          w_range_ok;
  logic          w_bad;
  logic [AW:0]   w_size;
  logic [AW:0]   w_last;

  logic          w_grant;
  logic          w_capture;

  // Winner selection: a lone request wins, a tie goes away from last_gnt.
  always_comb begin
    w_any = m0_req | m1_req;
    if (m0_req & m1_req) begin
      w_win = ~r_last_gnt;
    end else begin
      w_win = m1_req;
    end
    w_we    = w_win ? m1_we    : m0_we;
    w_addr  = w_win ? m1_addr  : m0_addr;
    w_wdata = w_win ? m1_wdata : m0_wdata;
    w_type  = w_win ? m1_type  : m0_type;
  end

  // Legality of the latched access: type, alignment and byte range.
  always_comb begin
    w_type_ok  = 1'b1;
    w_align_ok = 1'b1;
    w_size     = ONE;
    case (r_type)
      DM_WORD: begin
        w_size     = (AW+1)'(4);
        w_align_ok = (r_addr[1:0] == 2'b00);
      end
      DM_HALF, DM_HALF_U: begin
        w_size     = (AW+1)'(2);
        w_align_ok = ~r_addr[0];
      end
      DM_BYTE, DM_BYTE_U: begin
        w_size     = ONE;
      end
      default: begin
        w_type_ok  = 1'b0;
      end
    endcase
    w_last     = {1'b0, r_addr} + w_size - ONE;
    w_range_ok = (w_last < LIMIT);
    w_bad      = ~(w_type_ok & w_align_ok & w_range_ok);
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: IDLE -> ACCESS -> RESP -> IDLE, one cycle each.
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
          w_next  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_capture = ~r_we & ~w_bad;
        w_next    = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch and round-robin pointer, loaded on grant only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_gnt <= 1'b1;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_type     <= '0;
    end else if (w_grant) begin
      r_last_gnt <= w_win;
      r_owner    <= w_win;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_type     <= w_type;
    end
  end

  // Load data return, captured at the close of a legal load access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_capture) begin
      if (r_owner) begin
        r_rdata1 <= dm_dout;
      end else begin
        r_rdata0 <= dm_dout;
      end
    end
  end

  // Memory port and requester strobes decoded from the live state,
  // so an async reset drops the write enable at once.
  always_comb begin
    dm_DMWr   = (r_state == S_ACCESS) & r_we & ~w_bad;
    dm_addr   = r_addr;
    dm_din    = r_wdata;
    dm_DMType = r_type;
    busy      = (r_state != S_IDLE);
    m0_done   = (r_state == S_RESP) & ~r_owner & ~w_bad;
    m0_err    = (r_state == S_RESP) & ~r_owner &  w_bad;
    m1_done   = (r_state == S_RESP) &  r_owner & ~w_bad;
    m1_err    = (r_state == S_RESP) &  r_owner &  w_bad;
    m0_rdata  = r_rdata0;
    m1_rdata  = r_rdata1;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed vectors for dm_arbiter with a
// behavioural byte-addressed data memory on the dm side.
module tb_dm_arbiter;

  localparam logic [2:0] TW  = 3'b000;
  localparam logic [2:0] TH  = 3'b001;
  localparam logic [2:0] THU = 3'b010;
  localparam logic [2:0] TB  = 3'b011;
  localparam logic [2:0] TBU = 3'b100;
  localparam logic [2:0] TXX = 3'b111;

  logic        clk;
  logic        rstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [8:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [2:0]  m0_type, m1_type;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_DMWr;
  logic [8:0]  dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  dm_DMType;
  logic [31:0] dm_dout;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;

  logic       clr;
  logic [7:0] mem [0:511];
  logic [7:0] b0, b1, b2, b3;

  dm_arbiter dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_type(m0_type),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_type(m1_type),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dm_DMWr(dm_DMWr), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_DMType(dm_DMType), .dm_dout(dm_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read with extension, write on edge.
  always_comb begin
    b0 = mem[dm_addr];
    b1 = mem[dm_addr + 9'd1];
    b2 = mem[dm_addr + 9'd2];
    b3 = mem[dm_addr + 9'd3];
    case (dm_DMType)
      TW:      dm_dout = {b3, b2, b1, b0};
      TH:      dm_dout = {{16{b1[7]}}, b1, b0};
      THU:     dm_dout = {16'h0, b1, b0};
      TB:      dm_dout = {{24{b0[7]}}, b0};
      TBU:     dm_dout = {24'h0, b0};
      default: dm_dout = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h0;
    end else if (dm_DMWr) begin
      wr_cnt <= wr_cnt + 1;
      mem[dm_addr] <= dm_din[7:0];
      if (dm_DMType != TB && dm_DMType != TBU)
        mem[dm_addr + 9'd1] <= dm_din[15:8];
      if (dm_DMType == TW) begin
        mem[dm_addr + 9'd2] <= dm_din[23:16];
        mem[dm_addr + 9'd3] <= dm_din[31:24];
      end
    end
  end

  typedef struct {
    logic        m;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  ty;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic m, logic we, logic [8:0] a,
                              logic [31:0] d, logic [2:0] t,
                              logic e, logic [31:0] r);
    vec_t v;
    v.m = m; v.we = we; v.addr = a; v.wdata = d;
    v.ty = t; v.err = e; v.rdata = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [8:0] a, input logic [31:0] d,
                       input logic [2:0] t);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_type = t;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_type = t;
    end
  endtask

  // One access by a single requester, started in IDLE at a negedge;
  // returns in the following IDLE cycle, again at a negedge.
  task automatic do_access(input vec_t v, output logic done,
                           output logic err, output logic other,
                           output int cyc, output int wr,
                           output logic [31:0] rd);
    int w0;
    done = 0; err = 0; other = 0; cyc = 0;
    w0 = wr_cnt;
    drive(v.m, 1'b1, v.we, v.addr, v.wdata, v.ty);
    while (cyc < 10 && !(done | err)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      done  = v.m ? m1_done : m0_done;
      err   = v.m ? m1_err  : m0_err;
      other = other | (v.m ? (m0_done | m0_err) : (m1_done | m1_err));
    end
    drive(v.m, 1'b0, 1'b0, 9'h0, 32'h0, TW);
    wr = wr_cnt - w0;
    rd = v.m ? m1_rdata : m0_rdata;
    @(negedge clk);
  endtask

  // Wait for the next done pulse from either side; returns who, or -1.
  task automatic wait_pulse(output int who);
    who = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m0_done | m0_err) begin who = 0; break; end
      if (m1_done | m1_err) begin who = 1; break; end
    end
  endtask

  initial begin
    logic        d, e, o;
    int          cyc, wr, who;
    logic [31:0] rd;
    string       nm;

    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_type = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_type = 0;
    rstn = 0;
    clr  = 1;
    repeat (2) @(posedge clk);
    clr = 0;
    @(negedge clk);

    chk("rst_busy",   {31'h0, busy},    32'h0);
    chk("rst_dmwr",   {31'h0, dm_DMWr}, 32'h0);
    chk("rst_addr",   {23'h0, dm_addr}, 32'h0);
    chk("rst_din",    dm_din,           32'h0);
    chk("rst_pulses", {28'h0, m0_done, m0_err, m1_done, m1_err}, 32'h0);
    chk("rst_rdata0", m0_rdata,         32'h0);
    chk("rst_rdata1", m1_rdata,         32'h0);
    rstn = 1;
    @(negedge clk);

    // Fairness: both held high from the same cycle, M0 first.
    drive(0, 1, 0, 9'h000, 32'h0, TW);
    drive(1, 1, 0, 9'h004, 32'h0, TW);
    for (int k = 0; k < 6; k++) begin
      wait_pulse(who);
      chk($sformatf("rr_order%0d", k), who, k % 2);
    end
    drive(0, 0, 0, 9'h0, 32'h0, TW);
    drive(1, 0, 0, 9'h0, 32'h0, TW);
    @(negedge clk);
    chk("rr_idle", {31'h0, busy}, 32'h0);

    tv.push_back(mk(0, 1, 9'h010, 32'hDEADBEEF, TW,  0, 32'h00000000));
    tv.push_back(mk(0, 0, 9'h010, 32'h0,        TW,  0, 32'hDEADBEEF));
    tv.push_back(mk(1, 1, 9'h020, 32'h11223344, TW,  0, 32'h00000000));
    tv.push_back(mk(1, 1, 9'h021, 32'hAAAA5555, TH,  1, 32'h00000000));
    tv.push_back(mk(1, 1, 9'h022, 32'hAAAA5555, TW,  1, 32'h00000000));
    tv.push_back(mk(1, 0, 9'h020, 32'h0,        TW,  0, 32'h11223344));
    tv.push_back(mk(0, 1, 9'h07C, 32'hCAFEF00D, TW,  0, 32'hDEADBEEF));
    tv.push_back(mk(0, 0, 9'h07C, 32'h0,        TW,  0, 32'hCAFEF00D));
    tv.push_back(mk(0, 0, 9'h080, 32'h0,        TW,  1, 32'hCAFEF00D));
    tv.push_back(mk(0, 0, 9'h07F, 32'h0,        TH,  1, 32'hCAFEF00D));
    tv.push_back(mk(0, 0, 9'h07F, 32'h0,        TB,  0, 32'hFFFFFFCA));
    tv.push_back(mk(0, 0, 9'h07E, 32'h0,        THU, 0, 32'h0000CAFE));
    tv.push_back(mk(0, 1, 9'h030, 32'h00000080, TB,  0, 32'h0000CAFE));
    tv.push_back(mk(0, 0, 9'h030, 32'h0,        TB,  0, 32'hFFFFFF80));
    tv.push_back(mk(0, 0, 9'h030, 32'h0,        TBU, 0, 32'h00000080));
    tv.push_back(mk(0, 0, 9'h030, 32'h0,        TXX, 1, 32'h00000080));
    tv.push_back(mk(1, 0, 9'h07C, 32'h0,        TW,  0, 32'hCAFEF00D));

    foreach (tv[i]) begin
      do_access(tv[i], d, e, o, cyc, wr, rd);
      nm = $sformatf("v%0d", i);
      chk({nm, "_done"},  {31'h0, d}, {31'h0, ~tv[i].err});
      chk({nm, "_err"},   {31'h0, e}, {31'h0, tv[i].err});
      chk({nm, "_lat"},   cyc, 2);
      chk({nm, "_wr"},    wr, (tv[i].we & ~tv[i].err) ? 1 : 0);
      chk({nm, "_other"}, {31'h0, o}, 32'h0);
      chk({nm, "_rdata"}, rd, tv[i].rdata);
    end

    // Async reset in the middle of a store access.
    drive(0, 1, 1, 9'h040, 32'h12345678, TW);
    @(posedge clk);
    @(negedge clk);
    chk("ar_dmwr_hi", {31'h0, dm_DMWr}, 32'h1);
    chk("ar_busy_hi", {31'h0, busy},    32'h1);
    #2 rstn = 0;
    #1;
    chk("ar_dmwr_lo", {31'h0, dm_DMWr}, 32'h0);
    chk("ar_busy_lo", {31'h0, busy},    32'h0);
    drive(0, 0, 0, 9'h0, 32'h0, TW);
    o = 0;
    repeat (3) begin
      @(negedge clk);
      o = o | m0_done | m0_err | m1_done | m1_err;
    end
    chk("ar_nopulse", {31'h0, o}, 32'h0);
    chk("ar_rdata0",  m0_rdata,   32'h0);
    rstn = 1;
    @(negedge clk);

    drive(0, 1, 0, 9'h010, 32'h0, TW);
    drive(1, 1, 0, 9'h020, 32'h0, TW);
    wait_pulse(who);
    chk("ar_first", who, 0);
    chk("ar_m0_rd", m0_rdata, 32'hDEADBEEF);
    drive(0, 0, 0, 9'h0, 32'h0, TW);
    wait_pulse(who);
    chk("ar_second", who, 1);
    chk("ar_m1_rd",  m1_rdata, 32'h11223344);
    drive(1, 0, 0, 9'h0, 32'h0, TW);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
